inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
Parametrised instruction register successor: a DEPTH-entry FIFO of fetched instruction words with a valid/ready handshake on both sides.
- The head entry is presented pre-split into an opcode field (low OP_W bits) and an operand field (remaining upper bits).
- Sits between instruction memory fetch and the control/decode unit.
- Lets fetch run ahead of decode and lets a taken branch discard prefetched words via flush.

Parameters:
INST_W, 16, instruction word width in bits
OP_W, 5, opcode field width (bits [OP_W-1:0] of the word); 1 <= OP_W < INST_W
DEPTH, 4, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents a word this cycle
in_inst  in  INST_W  fetched instruction word
in_ready  out  1  queue can accept a word (= not full)
out_valid  out  1  head entry valid (= not empty)
out_ready  in  1  decode consumes head this cycle
flush  in  1  discard all entries (taken branch/jump)
out_op  out  OP_W  head[OP_W-1:0]; 0 when empty
out_fields  out  INST_W-OP_W  head[INST_W-1:OP_W]; 0 when empty
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (reset low, asynchronous, no clock needed):
  - read/write pointers = 0, count = 0, all storage = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_op = 0, out_fields = 0.
  - Reset held low: queue stays empty; pushes and pops are ignored.
- Push fires when in_valid && in_ready at a rising edge:
  - in_inst is written at the write pointer; the pointer increments modulo DEPTH.
- Pop fires when out_valid && out_ready at a rising edge:
  - read pointer increments modulo DEPTH.
- Latency: a word pushed at edge N is visible on out_op/out_fields with out_valid = 1 after edge N (one-cycle latency).
  - No combinational in->out bypass when empty.
- Output timing:
  - out_op/out_fields are combinational from the head storage register, gated to 0 when count == 0.
  - in_ready and out_valid are derived from count only.
  - No combinational path from in_valid/out_ready to any output.
- count update on a clock edge:
  - +1 on push only, -1 on pop only.
  - Unchanged on push+pop in the same cycle, or neither.
- Full (count == DEPTH): in_ready = 0 and pushes are ignored, even when out_ready = 1 in the same cycle. No write-through when full.
- Empty: out_ready is ignored. in_valid && out_ready in the same cycle while empty gives a push only.
- Flush (sampled at the edge) has the highest priority:
  - both pointers = 0, count = 0.
  - A concurrent push and pop are both discarded.
  - Storage contents are not cleared, but outputs read 0 because count == 0.
- Wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally; FIFO order is preserved across the wrap.
- An X on in_inst while in_valid = 0 must not affect state.

Optional Feature:
Macro: INST_QUEUE_STALL_CNT_EN
- Enabled:
  - Adds output stall_cnt, 16 bits.
  - Increments each cycle that in_valid && !in_ready (fetch stalled by a full queue), saturating at 0xFFFF.
  - Cleared by reset; not cleared by flush.
- Disabled: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package inst_pkg holds:
  - default INST_W/OP_W constants.
  - opcode field position constants (OP_LSB = 0, OP_MSB = OP_W-1).
  - typedef inst_word_t.
- Storage array and pointers live in a single module.
- One sub-module is natural: iq_ptr (modulo-DEPTH pointer register with inc and clear). It is instantiated twice, as read and write pointer.

Test Plan:
All tests use INST_W=16, OP_W=5, DEPTH=4.
- Reset then push 0xABCD -> after the edge: out_valid=1, out_op=0x0D, out_fields=0x55E, count=1. Pop -> out_valid=0, out_op=0, out_fields=0.
- Push 0x0001..0x0005 back-to-back, no pops -> count=4, in_ready=0 after 4th. 0x0005 dropped. Pops return 0x0001..0x0004 in order.
- Full queue, in_valid=1 and out_ready=1 same cycle -> pop only: count=3, in_ready=1 next cycle, pushed word not stored.
- Count=2, assert flush with in_valid=1 and out_ready=1 -> count=0, out_valid=0. Next push of 0x1234 becomes the head (out_op=0x14, out_fields=0x091).
- Stream 0x0001..0x000A with simultaneous push/pop after the first push -> pointers wrap twice, output order 0x0001..0x000A, count stays 1.
- Count=3, drive reset low mid-cycle (between edges) -> count=0, out_valid=0, in_ready=1 immediately. With the macro on: full queue plus in_valid=1 for 7 cycles -> stall_cnt=7, unchanged by a following flush.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared constants and types for the instruction queue: default word/opcode
// widths, opcode field position and the default instruction word type.
package inst_pkg;

    localparam int INST_W_DEF = 16;
    localparam int OP_W_DEF   = 5;
    localparam int DEPTH_DEF  = 4;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = OP_W_DEF - 1;

    typedef logic [INST_W_DEF-1:0] inst_word_t;

endpackage : inst_pkg

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
// INST_QUEUE_STALL_CNT_EN adds the fetch-stall counter output.
interface inst_queue_if
    import inst_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic [OP_W-1:0]   out_op;
    logic [INST_W-OP_W-1:0] out_fields;
    logic [CNT_W-1:0]  count;
`ifdef INST_QUEUE_STALL_CNT_EN
    logic [15:0]       stall_cnt;

    modport master (
        output in_valid, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_op, out_fields, count, stall_cnt
    );
    modport slave (
        input  in_valid, in_inst, out_ready, flush,
        output in_ready, out_valid, out_op, out_fields, count, stall_cnt
    );
`else
    modport master (
        output in_valid, in_inst, out_ready, flush,
        input  in_ready, out_valid, out_op, out_fields, count
    );
    modport slave (
        input  in_valid, in_inst, out_ready, flush,
        output in_ready, out_valid, out_op, out_fields, count
    );
`endif

endinterface : inst_queue_if

// File: rtl/inst_queue_ptr.sv
// Modulo-DEPTH pointer register with increment and synchronous clear;
// used for both the read and write side of the instruction queue.
module iq_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;

    // Next pointer: clear wins over increment; wrap is the natural overflow.
    always_comb begin
        w_ptr_next = r_ptr;
        if (i_clr) begin
            w_ptr_next = {PTR_W{1'b0}};
        end else if (i_inc) begin
            w_ptr_next = r_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            w_ptr_next = r_ptr;
        end
    end

    // Pointer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= {PTR_W{1'b0}};
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_ptr = r_ptr;

endmodule : iq_ptr

// File: rtl/inst_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode; head word is split
// into opcode/operand fields. Optional INST_QUEUE_STALL_CNT_EN stall counter.
module inst_queue
    import inst_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    inst_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INST_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [INST_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = bus.out_ready && !w_empty;

    iq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_push && !bus.flush),
        .i_clr (bus.flush),
        .o_ptr (w_wr_ptr)
    );

    iq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_pop && !bus.flush),
        .i_clr (bus.flush),
        .o_ptr (w_rd_ptr)
    );

    // Occupancy update; flush dominates and a simultaneous push+pop cancels.
    always_comb begin
        w_count_next = r_count;
        if (bus.flush) begin
            w_count_next = {CNT_W{1'b0}};
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_count_next = r_count;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_count <= w_count_next;
        end
    end

    // Storage write; flush leaves contents but blocks the concurrent write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {INST_W{1'b0}};
            end
        end else if (w_push && !bus.flush) begin
            r_mem[w_wr_ptr] <= bus.in_inst;
        end else begin
            r_mem[w_wr_ptr] <= r_mem[w_wr_ptr];
        end
    end

    // Head presentation, forced to zero whenever the queue is empty.
    always_comb begin
        w_head         = r_mem[w_rd_ptr];
        bus.out_op     = {OP_W{1'b0}};
        bus.out_fields = {(INST_W-OP_W){1'b0}};
        if (w_empty) begin
            bus.out_op     = {OP_W{1'b0}};
            bus.out_fields = {(INST_W-OP_W){1'b0}};
        end else begin
            bus.out_op     = w_head[OP_LSB +: OP_W];
            bus.out_fields = w_head[INST_W-1:OP_W];
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.count     = r_count;

`ifdef INST_QUEUE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles fetch is held off by a full queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'h0000;
        end else if (bus.in_valid && w_full && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue (INST_W=16, OP_W=5, DEPTH=4).
module tb_inst_queue;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [15:0] exp_q[$];

    inst_queue_if #(.INST_W(16), .OP_W(5), .DEPTH(4)) ifc ();

    inst_queue #(.INST_W(16), .OP_W(5), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] w);
        exp_q.push_back(w);
    endtask

    // Monitor: every pop that will fire at the next edge is checked in order.
    always @(negedge clk) begin
        if (reset && ifc.out_valid && ifc.out_ready && !ifc.flush) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_order: got %0h expected none", {ifc.out_fields, ifc.out_op});
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({ifc.out_fields, ifc.out_op} !== e) begin
                    n_fail++;
                    $display("FAIL pop_order: got %0h expected %0h", {ifc.out_fields, ifc.out_op}, e);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_inst   = 16'h5555;
        ifc.out_ready = 1'b0;
        ifc.flush     = 1'b0;
        #3;
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_op", 32'(ifc.out_op), 32'd0);
        chk("rst_out_fields", 32'(ifc.out_fields), 32'd0);
        tick();
        chk("rst_held_count", 32'(ifc.count), 32'd0);
        ifc.in_valid = 1'b0;
        reset = 1'b1;

        // Single push then pop
        ifc.in_valid = 1'b1; ifc.in_inst = 16'hABCD; push_exp(16'hABCD);
        tick();
        ifc.in_valid = 1'b0; ifc.in_inst = 16'hxxxx;
        chk("t1_valid", 32'(ifc.out_valid), 32'd1);
        chk("t1_op", 32'(ifc.out_op), 32'h0D);
        chk("t1_fields", 32'(ifc.out_fields), 32'h55E);
        chk("t1_count", 32'(ifc.count), 32'd1);
        tick();
        chk("x_idle_count", 32'(ifc.count), 32'd1);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk("t1_pop_valid", 32'(ifc.out_valid), 32'd0);
        chk("t1_pop_op", 32'(ifc.out_op), 32'd0);
        chk("t1_pop_fields", 32'(ifc.out_fields), 32'd0);

        // Fill past full; fifth word dropped
        for (int v = 1; v <= 5; v++) begin
            ifc.in_valid = 1'b1; ifc.in_inst = 16'(v);
            if (v <= 4) push_exp(16'(v));
            tick();
            if (v == 4) chk("t2_in_ready_full", 32'(ifc.in_ready), 32'd0);
        end
        chk("t2_count_full", 32'(ifc.count), 32'd4);

        // Full with push+pop: pop only
        ifc.in_valid = 1'b1; ifc.in_inst = 16'h00EE; ifc.out_ready = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        chk("t3_count", 32'(ifc.count), 32'd3);
        chk("t3_in_ready", 32'(ifc.in_ready), 32'd1);
        repeat (3) tick();
        ifc.out_ready = 1'b0;
        chk("t3_drained", 32'(ifc.count), 32'd0);

        // Flush with concurrent push and pop
        ifc.in_valid = 1'b1; ifc.in_inst = 16'h000A; push_exp(16'h000A); tick();
        ifc.in_inst = 16'h000B; push_exp(16'h000B); tick();
        chk("t4_count2", 32'(ifc.count), 32'd2);
        ifc.in_inst = 16'h000C; ifc.out_ready = 1'b1; ifc.flush = 1'b1;
        tick();
        exp_q.delete();
        ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        chk("t4_flush_count", 32'(ifc.count), 32'd0);
        chk("t4_flush_valid", 32'(ifc.out_valid), 32'd0);
        chk("t4_flush_op", 32'(ifc.out_op), 32'd0);
        ifc.in_valid = 1'b1; ifc.in_inst = 16'h1234; push_exp(16'h1234);
        tick();
        ifc.in_valid = 1'b0;
        chk("t4_head_op", 32'(ifc.out_op), 32'h14);
        chk("t4_head_fields", 32'(ifc.out_fields), 32'h091);
        ifc.out_ready = 1'b1; tick(); ifc.out_ready = 1'b0;

        // Streaming with wrap-around
        ifc.in_valid = 1'b1; ifc.in_inst = 16'h0001; push_exp(16'h0001); tick();
        for (int v = 2; v <= 10; v++) begin
            ifc.in_inst = 16'(v); ifc.out_ready = 1'b1; push_exp(16'(v));
            tick();
            chk("t5_count", 32'(ifc.count), 32'd1);
        end
        ifc.in_valid = 1'b0;
        tick();
        ifc.out_ready = 1'b0;
        chk("t5_drained", 32'(ifc.count), 32'd0);

        // Asynchronous reset mid-cycle
        ifc.in_valid = 1'b1;
        for (int v = 0; v < 3; v++) begin
            ifc.in_inst = 16'h0100 + 16'(v); push_exp(16'h0100 + 16'(v)); tick();
        end
        ifc.in_valid = 1'b0;
        chk("t6_count3", 32'(ifc.count), 32'd3);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_count", 32'(ifc.count), 32'd0);
        chk("t6_rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("t6_rst_in_ready", 32'(ifc.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

`ifdef INST_QUEUE_STALL_CNT_EN
        ifc.in_valid = 1'b1;
        for (int v = 0; v < 4; v++) begin
            ifc.in_inst = 16'h0200 + 16'(v); tick();
        end
        repeat (7) tick();
        ifc.in_valid = 1'b0;
        chk("t7_stall", 32'(ifc.stall_cnt), 32'd7);
        ifc.flush = 1'b1; tick(); ifc.flush = 1'b0;
        chk("t7_stall_flush", 32'(ifc.stall_cnt), 32'd7);
        chk("t7_flush_count", 32'(ifc.count), 32'd0);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_queue
